// File: rtl/ps2_key_rx_if.sv
// PS/2 keyboard front-end bundle: raw PS/2 pins in, toggle-coded key word out.
// master = the receiver block; slave = board pins / key decoder side.
interface ps2_key_rx_if;
  logic        ps2_clk;
  logic        ps2_dat;
  logic [10:0] ps2_key;
  logic        key_stb;
  logic        frame_err;

  modport master (
    input  ps2_clk,
    input  ps2_dat,
    output ps2_key,
    output key_stb,
    output frame_err
  );

  modport slave (
    output ps2_clk,
    output ps2_dat,
    input  ps2_key,
    input  key_stb,
    input  frame_err
  );
endinterface

// File: rtl/ps2_key_rx.sv
// PS/2 scan-code receiver: sync + clock filter, frame FSM, E0/F0/E1 prefix folding,
// emits {toggle, pressed, extended, code} words toward the key decoder.
module ps2_key_rx #(
  parameter int unsigned FILT_LEN = 8,
  parameter int unsigned TIMEOUT  = 96000
) (
  input  logic            clk,
  input  logic            rst,
  ps2_key_rx_if.master    bus
);

  localparam int unsigned   TW   = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TOUT = TW'(TIMEOUT);
  localparam logic [7:0]    FL1  = 8'(FILT_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic          r_c1, r_c2, r_d1, r_d2;
  logic          r_cf, r_cf_q;
  logic [7:0]    r_fcnt;
  logic [TW-1:0] r_tcnt;
  state_t        r_state;
  logic [7:0]    r_shift;
  logic [2:0]    r_bcnt;
  logic          r_par;
  logic          r_ext, r_brk;
  logic [2:0]    r_skip;
  logic [10:0]   r_key;
  logic          r_stb, r_err;

  state_t        w_state;
  logic [TW-1:0] w_tcnt;
  logic [7:0]    w_shift;
  logic [2:0]    w_bcnt;
  logic          w_par, w_ext, w_brk;
  logic [2:0]    w_skip;
  logic [10:0]   w_key;
  logic          w_stb, w_err;
  logic          w_fall, w_tout, w_ign;

  // Synchronisers and clock-level filter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_c1   <= 1'b1;
      r_c2   <= 1'b1;
      r_d1   <= 1'b1;
      r_d2   <= 1'b1;
      r_cf   <= 1'b1;
      r_cf_q <= 1'b1;
      r_fcnt <= '0;
    end else begin
      r_c1   <= bus.ps2_clk;
      r_c2   <= r_c1;
      r_d1   <= bus.ps2_dat;
      r_d2   <= r_d1;
      r_cf_q <= r_cf;
      if (r_c2 != r_cf) begin
        if (r_fcnt == FL1) begin
          r_cf   <= r_c2;
          r_fcnt <= '0;
        end else begin
          r_fcnt <= r_fcnt + 8'd1;
        end
      end else begin
        r_fcnt <= '0;
      end
    end
  end

  assign w_fall = r_cf_q & ~r_cf;
  assign w_tout = (r_state != S_IDLE) && (r_tcnt == TOUT);
  assign w_ign  = (r_shift == 8'hFA) || (r_shift == 8'hFE) || (r_shift == 8'hAA) ||
                  (r_shift == 8'hEE) || (r_shift == 8'h00) || (r_shift == 8'hFF);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_tcnt  <= '0;
      r_shift <= '0;
      r_bcnt  <= '0;
      r_par   <= 1'b0;
      r_ext   <= 1'b0;
      r_brk   <= 1'b0;
      r_skip  <= '0;
      r_key   <= '0;
      r_stb   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_tcnt  <= w_tcnt;
      r_shift <= w_shift;
      r_bcnt  <= w_bcnt;
      r_par   <= w_par;
      r_ext   <= w_ext;
      r_brk   <= w_brk;
      r_skip  <= w_skip;
      r_key   <= w_key;
      r_stb   <= w_stb;
      r_err   <= w_err;
    end
  end

  always_comb begin
    w_state = r_state;
    w_tcnt  = (r_state == S_IDLE || w_fall) ? '0 : r_tcnt + 1'b1;
    w_shift = r_shift;
    w_bcnt  = r_bcnt;
    w_par   = r_par;
    w_ext   = r_ext;
    w_brk   = r_brk;
    w_skip  = r_skip;
    w_key   = r_key;
    w_stb   = 1'b0;
    w_err   = 1'b0;

    // Timeout wins over a fall landing in the same cycle
    if (w_tout) begin
      w_state = S_IDLE;
      w_tcnt  = '0;
      w_err   = 1'b1;
      w_ext   = 1'b0;
      w_brk   = 1'b0;
      w_skip  = '0;
    end else if (w_fall) begin
      unique case (r_state)
        S_IDLE: begin
          if (!r_d2) begin
            w_state = S_DATA;
            w_bcnt  = '0;
          end else begin
            w_err  = 1'b1;
            w_ext  = 1'b0;
            w_brk  = 1'b0;
            w_skip = '0;
          end
        end
        S_DATA: begin
          w_shift = {r_d2, r_shift[7:1]};
          w_bcnt  = r_bcnt + 3'd1;
          if (r_bcnt == 3'd7) w_state = S_PARITY;
        end
        S_PARITY: begin
          w_par   = r_d2;
          w_state = S_STOP;
        end
        S_STOP: begin
          w_state = S_IDLE;
          if (r_d2 && (^{r_shift, r_par})) begin
            if (r_skip != '0) begin
              w_skip = r_skip - 3'd1;
            end else if (r_shift == 8'hE1) begin
              w_skip = 3'd7;
            end else if (r_shift == 8'hE0) begin
              w_ext = 1'b1;
            end else if (r_shift == 8'hF0) begin
              w_brk = 1'b1;
            end else if (!(w_ign && !r_ext && !r_brk)) begin
              w_key = {~r_key[10], ~r_brk, r_ext, r_shift};
              w_stb = 1'b1;
              w_ext = 1'b0;
              w_brk = 1'b0;
            end
          end else begin
            w_err  = 1'b1;
            w_ext  = 1'b0;
            w_brk  = 1'b0;
            w_skip = '0;
          end
        end
        default: w_state = S_IDLE;
      endcase
    end
  end

  assign bus.ps2_key   = r_key;
  assign bus.key_stb   = r_stb;
  assign bus.frame_err = r_err;

endmodule

// File: tb/tb_ps2_key_rx.sv
// Directed bench for ps2_key_rx: latency, prefixes, parity, timeout, glitch, Pause/ACK.
module tb_ps2_key_rx;
  localparam int unsigned FL = 4;
  localparam int unsigned TO = 400;
  localparam int unsigned HP = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   stb_cnt = 0;
  int   err_cnt = 0;
  int   both_cnt = 0;

  ps2_key_rx_if bus ();

  ps2_key_rx #(.FILT_LEN(FL), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst) begin
      if (bus.key_stb) stb_cnt++;
      if (bus.frame_err) err_cnt++;
      if (bus.key_stb && bus.frame_err) both_cnt++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog obs=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_neg(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    bus.ps2_dat = b;
    wait_neg(HP);
    bus.ps2_clk = 1'b0;
    wait_neg(HP);
    bus.ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par_flip);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ par_flip, b, 1'b0};
    for (int i = 0; i < 11; i++) send_bit(bits[i]);
    wait_neg(HP);
  endtask

  initial begin
    logic [10:0] bits;
    logic [7:0]  seq [10];
    int          s0, e0;

    bus.ps2_clk = 1'b1;
    bus.ps2_dat = 1'b1;
    wait_neg(5);
    chk("rst_key", 32'(bus.ps2_key), 32'h000);
    chk("rst_stb", 32'(bus.key_stb), 32'd0);
    chk("rst_err", 32'(bus.frame_err), 32'd0);
    rst = 1'b0;
    wait_neg(10);

    // Make code 0x1C with stop-bit latency check
    bits = {1'b1, 1'b0, 8'h1C, 1'b0};
    for (int i = 0; i < 10; i++) send_bit(bits[i]);
    @(negedge clk);
    bus.ps2_dat = 1'b1;
    wait_neg(HP);
    bus.ps2_clk = 1'b0;
    wait_neg(FL + 2);
    chk("lat_early", 32'(bus.key_stb), 32'd0);
    wait_neg(1);
    chk("lat_stb", 32'(bus.key_stb), 32'd1);
    chk("make_key", 32'(bus.ps2_key), 32'h61C);
    wait_neg(1);
    chk("stb_1cyc", 32'(bus.key_stb), 32'd0);
    wait_neg(HP);
    bus.ps2_clk = 1'b1;
    wait_neg(HP);
    chk("make_cnt", 32'(stb_cnt), 32'd1);

    // Extended break
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    chk("pre_nostb", 32'(stb_cnt), 32'd1);
    send_frame(8'h75, 1'b0);
    chk("brk_key", 32'(bus.ps2_key), 32'h175);
    chk("brk_cnt", 32'(stb_cnt), 32'd2);

    // Parity error clears the pending E0
    send_frame(8'hE0, 1'b0);
    send_frame(8'h1C, 1'b1);
    chk("par_err", 32'(err_cnt), 32'd1);
    chk("par_nostb", 32'(stb_cnt), 32'd2);
    send_frame(8'h1C, 1'b0);
    chk("par_key", 32'(bus.ps2_key), 32'h61C);
    chk("par_cnt", 32'(stb_cnt), 32'd3);

    // Timeout mid-frame
    bits = {1'b1, 1'b0, 8'h29, 1'b0};
    for (int i = 0; i < 5; i++) send_bit(bits[i]);
    wait_neg(TO + 60);
    chk("to_err", 32'(err_cnt), 32'd2);
    send_frame(8'h29, 1'b0);
    chk("to_key", 32'(bus.ps2_key), 32'h229);
    chk("to_cnt", 32'(stb_cnt), 32'd4);

    // Short clock glitch while idle
    @(negedge clk);
    bus.ps2_clk = 1'b0;
    wait_neg(FL - 1);
    bus.ps2_clk = 1'b1;
    wait_neg(30);
    chk("gl_err", 32'(err_cnt), 32'd2);
    chk("gl_stb", 32'(stb_cnt), 32'd4);
    send_frame(8'h05, 1'b0);
    chk("gl_key", 32'(bus.ps2_key), 32'h605);

    // Pause sequence, ACK, then a real key
    seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'hFA, 8'h06};
    s0 = stb_cnt;
    e0 = err_cnt;
    for (int i = 0; i < 9; i++) send_frame(seq[i], 1'b0);
    chk("pause_nostb", 32'(stb_cnt - s0), 32'd0);
    send_frame(seq[9], 1'b0);
    chk("pause_stb", 32'(stb_cnt - s0), 32'd1);
    chk("pause_key", 32'(bus.ps2_key), 32'h206);
    chk("pause_err", 32'(err_cnt - e0), 32'd0);
    chk("no_overlap", 32'(both_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ps2_key_rx.md
# ps2_key_rx

Keyboard front end for the arcade core. Deserialises the raw PS/2 clock/data lines into scan-code frames, folds the E0/F0 prefixes and emits the 11-bit toggle-coded `ps2_key` word. The core's existing key decoder consumes that word by watching bit 10 change, then reading pressed (bit 9) and code (bits 7:0). The block sits between the board PS/2 pins and that decoder; it transmits only toward the decoder and never drives the PS/2 lines.

## Interface
- `FILT_LEN`, default 8: consecutive equal samples needed to accept a `ps2_clk` level change; range 2–255.
- `TIMEOUT`, default 96000: clk cycles without a filtered `ps2_clk` fall before an in-progress frame is aborted (2 ms at 48 MHz).
- `clk` in 1: system clock; single clock domain.
- `rst` in 1: asynchronous, active-high reset.
- `ps2_clk` in 1: raw PS/2 clock, asynchronous.
- `ps2_dat` in 1: raw PS/2 data, asynchronous.
- `ps2_key` out 11: {toggle, pressed, extended, code[7:0]}.
- `key_stb` out 1: one-cycle pulse when `ps2_key` updates.
- `frame_err` out 1: one-cycle pulse on parity, start, stop or timeout error.

## Operation
- Both raw inputs pass through 2-flop synchronisers (`c2`, `d2`).
- Clock filter: `cf` resets to 1. `cf` takes the value of `c2` after `c2` has differed from `cf` for `FILT_LEN` consecutive cycles. Any equal sample clears the count.
- A fall is detected when `cf` is 1 in one cycle and 0 in the next. The bit value is `d2` in the detect cycle.
- Frame FSM, one step per fall:
  - IDLE: bit 0 → DATA with count 0. Bit 1 is a start error: pulse `frame_err`, stay in IDLE.
  - DATA: shift LSB-first. After 8 bits → PARITY.
  - PARITY: store the bit → STOP.
  - STOP: the frame is good if stop = 1 and XOR(data, parity) = 1 (odd parity). Otherwise pulse `frame_err`. Either way → IDLE.
- Timeout: in DATA, PARITY or STOP, a counter counts cycles since the last fall. Reaching `TIMEOUT` pulses `frame_err` and returns to IDLE. The counter is cleared on each fall and while in IDLE.
- Any `frame_err` clears `ext`, `brk` and `skip`.
- Good-byte handling, in priority order:
  1. `skip` ≠ 0: decrement `skip`, no emit.
  2. Byte 0xE1: `skip` = 7, no emit. The Pause sequence is swallowed.
  3. Byte 0xE0: set `ext`.
  4. Byte 0xF0: set `brk`.
  5. Bytes 0xFA, 0xFE, 0xAA, 0xEE, 0x00, 0xFF with `ext` = `brk` = 0: discard.
  6. Any other byte: `ps2_key` ← {~ps2_key[10], ~brk, ext, byte}, `key_stb` = 1, clear `ext` and `brk`.
- Reset values:
  - `ps2_key` = 0, `key_stb` = 0, `frame_err` = 0.
  - FSM = IDLE; `ext`, `brk`, `skip` = 0.
  - `cf` = 1, synchroniser flops = 1, all counters = 0.
- Reset mid-frame: the partial frame is discarded. The next frame is decoded normally once `cf` has settled high.

## Timing
- Latency: with raw lines held stable, `key_stb` and the new `ps2_key` appear exactly `FILT_LEN`+3 clk cycles after the raw `ps2_clk` fall of the stop bit. `frame_err` has the same latency.
- `ps2_key` holds its value between updates; only bit 10 signals a new event.
- `key_stb` and `frame_err` are never asserted in the same cycle. Each is high for exactly 1 cycle.
- The timeout check takes precedence over a fall arriving in the same cycle.
- Data must be stable for ≥3 cycles before and through the filtered fall. PS/2 guarantees ≥5 µs.
- Minimum supported PS/2 half period: `FILT_LEN`+4 cycles.

## Test plan
- Make code: from reset, send frame 0x1C (parity 0, stop 1) → one `key_stb`, `ps2_key` = 0x61C, after exactly `FILT_LEN`+3 cycles.
- Break plus extended: send 0xE0, 0xF0, 0x75 → no strobe on the first two bytes. After the third, `ps2_key` = {~prev toggle, 0, 1, 0x75}; from 0x61C the result is 0x175.
- Parity error: send 0xE0, then 0x1C with parity 1 → `frame_err` pulse, no strobe. A following good 0x1C gives `ps2_key` = 0x61C with ext clear.
- Timeout: send start plus 4 data bits, then idle for `TIMEOUT` cycles → one `frame_err`. A full 0x29 frame afterwards decodes to {toggle, 1, 0, 0x29}.
- Glitch rejection: pulse raw `ps2_clk` low for `FILT_LEN`−1 cycles while idle → no state change. A full 0x05 frame then decodes correctly.
- Pause and ACK: send E1 14 77 E1 F0 14 F0 77, then 0xFA, then 0x06 → exactly one strobe, with `ps2_key`[7:0] = 0x06 and pressed = 1.
